shift_issue: RTL and testbench

SHIFT_ISSUE -- requirements
Module: shift_issue

---
 rtl/shift_issue_if.sv | 28 ++
 rtl/shift_issue.sv | 113 +++++++++++
 tb/tb_shift_issue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_if.sv
// Request/issue/result signal bundle for shift_issue.
// slave is the issue block itself; master is the upstream/shifter/consumer side.
interface shift_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] in_op;
  logic [3:0] sh_a;
  logic [3:0] sh_b;
  logic [3:0] sh_op;
  logic [3:0] sh_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_op;
  logic       err_op;

  modport slave (
    input  in_valid, in_a, in_b, in_op, sh_result, out_ready,
    output in_ready, sh_a, sh_b, sh_op, out_valid, out_data, out_op, err_op
  );

  modport master (
    output in_valid, in_a, in_b, in_op, sh_result, out_ready,
    input  in_ready, sh_a, sh_b, sh_op, out_valid, out_data, out_op, err_op
  );
endinterface

// File: rtl/shift_issue.sv
// Request FIFO feeding an external combinational shifter, one result held at a time.
// Define SHIFT_ISSUE_BYPASS_EN to let a request into an idle, empty block skip the FIFO.
//
// state | meaning
// IDLE  | no request in flight, waiting for FIFO data
// ISSUE | issue register drives the shifter, result captured at next edge
// HOLD  | result held on out_data/out_op until the consumer accepts
module shift_issue #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  shift_issue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          bypass;
  logic          fifo_push;
  logic          pop;
  logic          illegal;
  logic [11:0]   head;

  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
`ifdef SHIFT_ISSUE_BYPASS_EN
  assign bypass       = push && (state == IDLE) && (count == '0);
`else
  assign bypass       = 1'b0;
`endif
  assign fifo_push    = push && !bypass;
  // HOLD always has out_valid set, so out_ready alone completes the handshake
  assign pop          = (count != '0) &&
                        ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign head         = mem[rd_ptr];
  assign illegal      = (bus.sh_op > 4'b0011);

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.sh_a      <= '0;
      bus.sh_b      <= '0;
      bus.sh_op     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_op    <= '0;
      bus.err_op    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {bus.sh_a, bus.sh_b, bus.sh_op} <= head;
            state <= ISSUE;
          end else if (bypass) begin
            {bus.sh_a, bus.sh_b, bus.sh_op} <= {bus.in_a, bus.in_b, bus.in_op};
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.out_valid <= 1'b1;
          bus.out_op    <= bus.sh_op;
          if (illegal) begin
            bus.out_data <= 4'b0000;
            bus.err_op   <= 1'b1;
          end else begin
            bus.out_data <= bus.sh_result;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (pop) begin
              {bus.sh_a, bus.sh_b, bus.sh_op} <= head;
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: scoreboard queue filled on accept, drained on result handshake.
// The bench also plays the downstream shifter (0 sll, 1 rotl, 2 srl, 3 sra).
module tb_shift_issue;
`ifdef SHIFT_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  shift_issue_if bus();

  shift_issue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] shf(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic signed [3:0] sb;
    logic [7:0]        d;
    logic [3:0]        r;
    sb = b;
    d  = {b, b} << a[1:0];
    case (op)
      4'd0:    r = b << a;
      4'd1:    r = d[7:4];
      4'd2:    r = b >> a;
      4'd3:    r = sb >>> a;
      default: r = 4'b1010;
    endcase
    return r;
  endfunction

  always_comb bus.sh_result = shf(bus.sh_a, bus.sh_b, bus.sh_op);

  exp_t sbq[$];
  exp_t cur_exp;
  exp_t got_e;
  int   tests = 0;
  int   fails = 0;
  int   nout  = 0;
  int   cyc   = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    acc = 1'b0;
    @(negedge clk);
    if (rst_n && bus.in_valid && bus.in_ready) begin
      sbq.push_back(cur_exp);
      acc = 1'b1;
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("result_expected", 8'(sbq.size() != 0), 8'd1);
      if (sbq.size() != 0) begin
        got_e = sbq.pop_front();
        chk("out_data", 8'(bus.out_data), 8'(got_e.data));
        chk("out_op", 8'(bus.out_op), 8'(got_e.op));
      end
      nout++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      input logic [3:0] want);
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    cur_exp      = '{op: op, data: want};
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 40);
    chk("accepted", 8'(acc), 8'd1);
  endtask

  task automatic send_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    send(a, b, op, (op > 4'd3) ? 4'b0000 : shf(a, b, op));
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    while (nout < target && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_count", 8'(nout), 8'(target));
    chk("sb_empty", 8'(sbq.size()), 8'd0);
  endtask

  task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] want);
    int lat;
    int base;
    bus.out_ready = 1'b1;
    send(a, b, op, want);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 8) begin
      cycle();
      lat++;
    end
    chk("latency", 8'(lat), 8'(LAT));
    chk("first_out_data", 8'(bus.out_data), 8'(want));
    chk("first_out_op", 8'(bus.out_op), 8'(op));
    base = nout;
    cycle();
    chk("popped", 8'(nout), 8'(base + 1));
    chk("valid_fall", 8'(bus.out_valid), 8'd0);
    chk("sh_a_hold", 8'(bus.sh_a), 8'(a));
    chk("sh_b_hold", 8'(bus.sh_b), 8'(b));
    chk("sh_op_hold", 8'(bus.sh_op), 8'(op));
    chk("sb_empty_single", 8'(sbq.size()), 8'd0);
  endtask

  initial begin
    int base;
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;

    #12;
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
    chk("rst_err_op", 8'(bus.err_op), 8'd0);
    chk("rst_out_data", 8'(bus.out_data), 8'd0);
    chk("rst_out_op", 8'(bus.out_op), 8'd0);
    chk("rst_sh", 8'({bus.sh_a, bus.sh_b} | {4'h0, bus.sh_op}), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // single request and arithmetic path
    single(4'd1, 4'b0011, 4'd0, 4'b0110);
    single(4'd1, 4'b1000, 4'd3, 4'b1100);
    single(4'd1, 4'b1000, 4'd2, 4'b0100);

    // illegal opcode, then a legal op must not clear the sticky flag
    single(4'd1, 4'b1111, 4'd5, 4'b0000);
    chk("err_set", 8'(bus.err_op), 8'd1);
    single(4'd2, 4'b0001, 4'd0, 4'b0100);
    chk("err_sticky", 8'(bus.err_op), 8'd1);

    // full backpressure
    bus.out_ready = 1'b0;
    base = nout;
    for (int i = 0; i < 5; i++) send_model(4'(i), 4'(15 - i), 4'(i % 4));
    bus.in_valid = 1'b0;
    chk("bp_full_ready", 8'(bus.in_ready), 8'd0);
    chk("bp_held_valid", 8'(bus.out_valid), 8'd1);
    repeat (3) cycle();
    chk("bp_still_full", 8'(bus.in_ready), 8'd0);
    chk("bp_held_data", 8'(bus.out_data), 8'(sbq[0].data));
    chk("bp_held_op", 8'(bus.out_op), 8'(sbq[0].op));
    chk("bp_none_out", 8'(nout), 8'(base));
    bus.out_ready = 1'b1;
    chk("bp_full_on_pop", 8'(bus.in_ready), 8'd0);
    send_model(4'd2, 4'b0110, 4'd1);
    bus.in_valid = 1'b0;
    drain(base + 6);

    // reset mid-operation: one result held, three queued
    bus.out_ready = 1'b0;
    base = nout;
    for (int i = 0; i < 4; i++) send_model(4'(i + 1), 4'b1001, 4'(i % 4));
    bus.in_valid = 1'b0;
    cycle();
    chk("pre_rst_hold", 8'(bus.out_valid), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(bus.out_valid), 8'd0);
    chk("mid_rst_ready", 8'(bus.in_ready), 8'd1);
    chk("mid_rst_err", 8'(bus.err_op), 8'd0);
    chk("mid_rst_data", 8'(bus.out_data), 8'd0);
    chk("mid_rst_sh_op", 8'(bus.sh_op), 8'd0);
    sbq.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) cycle();
    chk("post_rst_silent", 8'(nout), 8'(base));
    single(4'd1, 4'b0011, 4'd0, 4'b0110);

    // wrap-around, back-to-back
    bus.out_ready = 1'b1;
    base = nout;
    c0 = cyc;
    for (int i = 0; i < 10; i++)
      send_model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
    bus.in_valid = 1'b0;
    drain(base + 10);
    chk("wrap_no_gaps", 8'((cyc - c0) <= (2 * 10 + LAT + 1)), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
